// File: rtl/game_overlay_renderer.sv
// Final video compositor: wall blend, collision highlight, depth bar and game-over flash
// over the annotated camera stream, plus a per-frame collision pixel count.
module game_overlay_renderer #(
    parameter int unsigned SCREEN_WIDTH    = 1280,
    parameter int unsigned SCREEN_HEIGHT   = 720,
    parameter logic [15:0] WALL_COLOR      = 16'h07E0,
    parameter logic [15:0] COLLISION_COLOR = 16'hF800,
    parameter logic [15:0] BAR_COLOR       = 16'h001F,
    parameter int unsigned BAR_HEIGHT      = 16,
    parameter int unsigned BAR_SCALE       = 8,
    parameter int unsigned FLASH_FRAMES    = 15
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [15:0] pixel_in,
    input  logic        data_valid_in,
    input  logic        is_wall_in,
    input  logic        is_person_in,
    input  logic        is_collision_in,
    input  logic [7:0]  wall_depth_in,
    input  logic [7:0]  player_depth_in,
    input  logic [2:0]  game_state_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic [15:0] pixel_out,
    output logic        data_valid_out,
    output logic [19:0] collision_count_out,
    output logic        frame_done_out,
    output logic        flash_active_out
);

    localparam int unsigned HC_W   = 11;
    localparam int unsigned VC_W   = 10;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned FCNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_PLAYING  = 2'd0,
        ST_OVER_ON  = 2'd1,
        ST_OVER_OFF = 2'd2
    } flash_state_t;

    flash_state_t      state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  run_q, run_inc;

    logic              frame_end;
    logic              in_bar;
    logic [PROD_W-1:0] hc_ext, player_px, wall_px;

    logic [HC_W-1:0]   s1_hc;
    logic [VC_W-1:0]   s1_vc;
    logic [PIX_W-1:0]  s1_pix;
    logic              s1_valid, s1_bar_player, s1_bar_wall, s1_coll, s1_wall, s1_invert;

    logic [4:0]        blend_r, blend_b;
    logic [5:0]        blend_g;
    logic [PIX_W-1:0]  composite;

    // Person flag is carried for upstream symmetry; it does not affect compositing.
    logic              person_unused;
    assign person_unused = is_person_in;

    assign frame_end = data_valid_in
                    && (hcount_in == HC_W'(SCREEN_WIDTH - 1))
                    && (vcount_in == VC_W'(SCREEN_HEIGHT - 1));

    assign in_bar    = vcount_in < VC_W'(BAR_HEIGHT);
    assign hc_ext    = PROD_W'(hcount_in);
    assign player_px = PROD_W'(player_depth_in) * PROD_W'(BAR_SCALE);
    assign wall_px   = PROD_W'(wall_depth_in) * PROD_W'(BAR_SCALE);

    // Saturating running collision count including the current pixel.
    assign run_inc = (data_valid_in && is_collision_in && (run_q != CNT_MAX))
                   ? run_q + CNT_W'(1) : run_q;

    // Stage 1: register the pixel with its pre-decoded overlay decisions.
    // The invert flag is captured here so a frame-end state change never affects
    // pixels that entered before it.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_hc         <= '0;
            s1_vc         <= '0;
            s1_pix        <= '0;
            s1_valid      <= 1'b0;
            s1_bar_player <= 1'b0;
            s1_bar_wall   <= 1'b0;
            s1_coll       <= 1'b0;
            s1_wall       <= 1'b0;
            s1_invert     <= 1'b0;
        end else begin
            s1_hc         <= hcount_in;
            s1_vc         <= vcount_in;
            s1_pix        <= pixel_in;
            s1_valid      <= data_valid_in;
            s1_bar_player <= in_bar && (hc_ext == player_px);
            s1_bar_wall   <= in_bar && (hc_ext < wall_px);
            s1_coll       <= is_collision_in;
            s1_wall       <= is_wall_in;
            s1_invert     <= (state_q == ST_OVER_ON);
        end
    end

    // Halved channels cannot overflow when summed.
    assign blend_r = (s1_pix[15:11] >> 1) + (WALL_COLOR[15:11] >> 1);
    assign blend_g = (s1_pix[10:5]  >> 1) + (WALL_COLOR[10:5]  >> 1);
    assign blend_b = (s1_pix[4:0]   >> 1) + (WALL_COLOR[4:0]   >> 1);

    // Stage 2 priority resolution.
    always_comb begin
        composite = s1_pix;
        if (s1_bar_player) begin
            composite = 16'hFFFF;
        end else if (s1_bar_wall) begin
            composite = BAR_COLOR;
        end else if (s1_coll) begin
            composite = COLLISION_COLOR;
        end else if (s1_wall) begin
            composite = {blend_r, blend_g, blend_b};
        end
        if (s1_invert) begin
            composite = ~composite;
        end
        if (!s1_valid) begin
            composite = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hcount_out       <= '0;
            vcount_out       <= '0;
            pixel_out        <= '0;
            data_valid_out   <= 1'b0;
            flash_active_out <= 1'b0;
        end else begin
            hcount_out       <= s1_hc;
            vcount_out       <= s1_vc;
            pixel_out        <= composite;
            data_valid_out   <= s1_valid;
            flash_active_out <= (state_q == ST_OVER_ON);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            run_q               <= '0;
            collision_count_out <= '0;
            frame_done_out      <= 1'b0;
        end else if (frame_end) begin
            run_q               <= '0;
            collision_count_out <= run_inc;
            frame_done_out      <= 1'b1;
        end else begin
            run_q               <= run_inc;
            frame_done_out      <= 1'b0;
        end
    end

    // Flash FSM state register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= ST_PLAYING;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Flash FSM next state; only frame-end cycles can move it.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (frame_end) begin
            case (state_q)
                ST_PLAYING: begin
                    if (game_state_in == 3'd0) begin
                        state_d = ST_OVER_ON;
                        fcnt_d  = '0;
                    end
                end
                ST_OVER_ON, ST_OVER_OFF: begin
                    if (game_state_in != 3'd0) begin
                        state_d = ST_PLAYING;
                        fcnt_d  = '0;
                    end else if (fcnt_q == FCNT_W'(FLASH_FRAMES - 1)) begin
                        state_d = (state_q == ST_OVER_ON) ? ST_OVER_OFF : ST_OVER_ON;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d  = fcnt_q + FCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_PLAYING;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_overlay_renderer.sv
// Self-checking bench for game_overlay_renderer: behavioural model with per-cycle
// compare, plus directed vectors with hand-computed expectations.
module tb_game_overlay_renderer;

    localparam logic [15:0] WALL_C = 16'h07E0;
    localparam logic [15:0] COLL_C = 16'hF800;
    localparam logic [15:0] BAR_C  = 16'h001F;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] pixel_in;
    logic        data_valid_in, is_wall_in, is_person_in, is_collision_in;
    logic [7:0]  wall_depth_in, player_depth_in;
    logic [2:0]  game_state_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [15:0] pixel_out;
    logic        data_valid_out;
    logic [19:0] collision_count_out;
    logic        frame_done_out, flash_active_out;

    int checks = 0;
    int errors = 0;

    game_overlay_renderer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pixel_in(pixel_in),
        .data_valid_in(data_valid_in), .is_wall_in(is_wall_in),
        .is_person_in(is_person_in), .is_collision_in(is_collision_in),
        .wall_depth_in(wall_depth_in), .player_depth_in(player_depth_in),
        .game_state_in(game_state_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out), .pixel_out(pixel_out),
        .data_valid_out(data_valid_out), .collision_count_out(collision_count_out),
        .frame_done_out(frame_done_out), .flash_active_out(flash_active_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level pixel rule: bar, collision, wall blend, pass-through, then inversion.
    function automatic logic [15:0] model_pixel(input int hc, input int vc, input logic [15:0] pix,
                                                input logic w, input logic c, input int wd,
                                                input int pd, input logic inv);
        logic [15:0] res;
        int r, g, b;
        if (vc < 16 && hc == pd * 8)      res = 16'hFFFF;
        else if (vc < 16 && hc < wd * 8)  res = BAR_C;
        else if (c)                       res = COLL_C;
        else if (w) begin
            r = int'(pix[15:11]) / 2 + int'(WALL_C[15:11]) / 2;
            g = int'(pix[10:5])  / 2 + int'(WALL_C[10:5])  / 2;
            b = int'(pix[4:0])   / 2 + int'(WALL_C[4:0])   / 2;
            res = {r[4:0], g[5:0], b[4:0]};
        end else                          res = pix;
        return inv ? ~res : res;
    endfunction

    typedef struct packed {
        logic [10:0] hc;
        logic [9:0]  vc;
        logic [15:0] pix;
        logic        v;
    } exp_t;

    exp_t        m_mid, m_out;
    logic [19:0] m_run, m_cnt;
    logic        m_done, m_flash;
    int          m_state;   // 0 playing, 1 flash on, 2 flash off
    int          m_fc;
    bit          model_ready = 1'b0;

    // Model update at each active edge, reading the inputs the DUT samples.
    always @(posedge clk_in) begin : model
        exp_t nxt;
        logic fe;
        if (!rst_in) begin
            m_mid = '0; m_out = '0; m_run = '0; m_cnt = '0;
            m_done = 1'b0; m_flash = 1'b0; m_state = 0; m_fc = 0;
            model_ready = 1'b1;
        end else if (model_ready) begin
            nxt.hc  = hcount_in;
            nxt.vc  = vcount_in;
            nxt.v   = data_valid_in;
            nxt.pix = data_valid_in
                    ? model_pixel(int'(hcount_in), int'(vcount_in), pixel_in, is_wall_in,
                                  is_collision_in, int'(wall_depth_in), int'(player_depth_in),
                                  m_state == 1)
                    : 16'h0000;
            m_out   = m_mid;
            m_mid   = nxt;
            m_flash = (m_state == 1);
            m_done  = 1'b0;
            if (data_valid_in && is_collision_in && m_run != 20'hFFFFF) m_run = m_run + 20'd1;
            fe = data_valid_in && hcount_in == 11'd1279 && vcount_in == 10'd719;
            if (fe) begin
                m_cnt  = m_run;
                m_run  = '0;
                m_done = 1'b1;
                if (m_state == 0) begin
                    if (game_state_in == 3'd0) begin m_state = 1; m_fc = 0; end
                end else if (game_state_in != 3'd0) begin
                    m_state = 0; m_fc = 0;
                end else if (m_fc == 14) begin
                    m_state = (m_state == 1) ? 2 : 1; m_fc = 0;
                end else begin
                    m_fc = m_fc + 1;
                end
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (model_ready) begin
            chk("hcount_out",          32'(hcount_out),          32'(m_out.hc));
            chk("vcount_out",          32'(vcount_out),          32'(m_out.vc));
            chk("pixel_out",           32'(pixel_out),           32'(m_out.pix));
            chk("data_valid_out",      32'(data_valid_out),      32'(m_out.v));
            chk("collision_count_out", 32'(collision_count_out), 32'(m_cnt));
            chk("frame_done_out",      32'(frame_done_out),      32'(m_done));
            chk("flash_active_out",    32'(flash_active_out),    32'(m_flash));
        end
    end

    logic [7:0] cur_wd, cur_pd;
    logic [2:0] cur_gs;

    task automatic px(input int hc, input int vc, input logic [15:0] pix,
                      input logic w, input logic c);
        hcount_in = 11'(hc); vcount_in = 10'(vc); pixel_in = pix;
        data_valid_in = 1'b1; is_wall_in = w; is_collision_in = c; is_person_in = c;
        wall_depth_in = cur_wd; player_depth_in = cur_pd; game_state_in = cur_gs;
        @(posedge clk_in); #1;
    endtask

    task automatic idle();
        hcount_in = '0; vcount_in = '0; pixel_in = '0;
        data_valid_in = 1'b0; is_wall_in = 1'b0; is_collision_in = 1'b0; is_person_in = 1'b0;
        wall_depth_in = cur_wd; player_depth_in = cur_pd; game_state_in = cur_gs;
        @(posedge clk_in); #1;
    endtask

    initial begin
        logic inv;
        cur_wd = 8'd0; cur_pd = 8'd0; cur_gs = 3'd1;
        rst_in = 1'b0;
        hcount_in = '0; vcount_in = '0; pixel_in = '0;
        data_valid_in = 1'b0; is_wall_in = 1'b0; is_person_in = 1'b0; is_collision_in = 1'b0;
        wall_depth_in = '0; player_depth_in = '0; game_state_in = 3'd1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            chk("reset pixel_out", 32'(pixel_out), 32'h0);
            chk("reset valid_out", 32'(data_valid_out), 32'h0);
            chk("reset count_out", 32'(collision_count_out), 32'h0);
            chk("reset frame_done", 32'(frame_done_out), 32'h0);
            chk("reset flash", 32'(flash_active_out), 32'h0);
            chk("reset hcount_out", 32'(hcount_out), 32'h0);
        end
        rst_in = 1'b1;

        px(100, 300, 16'h1234, 1'b0, 1'b0); idle();
        chk("passthrough pixel", 32'(pixel_out), 32'h1234);
        chk("passthrough hcount", 32'(hcount_out), 32'd100);
        chk("passthrough vcount", 32'(vcount_out), 32'd300);
        chk("passthrough valid", 32'(data_valid_out), 32'h1);

        px(50, 300, 16'hFFFF, 1'b1, 1'b0); idle();
        chk("wall blend", 32'(pixel_out), 32'h7FCF);
        px(50, 300, 16'hFFFF, 1'b1, 1'b1); idle();
        chk("collision color", 32'(pixel_out), 32'hF800);

        cur_wd = 8'd10; cur_pd = 8'd5;
        px(40, 3, 16'h1234, 1'b0, 1'b0); idle();
        chk("bar player marker", 32'(pixel_out), 32'hFFFF);
        px(79, 3, 16'h1234, 1'b0, 1'b0); idle();
        chk("bar wall fill", 32'(pixel_out), 32'h001F);
        px(80, 3, 16'h1234, 1'b0, 1'b0); idle();
        chk("bar past end", 32'(pixel_out), 32'h1234);
        px(80, 16, 16'hFFFF, 1'b1, 1'b0); idle();
        chk("below bar blend", 32'(pixel_out), 32'h7FCF);
        cur_wd = 8'd0; cur_pd = 8'd0;

        // Close the partial frame holding the single collision pixel above.
        px(1279, 719, 16'h0000, 1'b0, 1'b0);
        chk("flush count", 32'(collision_count_out), 32'd1);
        chk("flush frame_done", 32'(frame_done_out), 32'h1);

        for (int i = 0; i < 499; i++) px(i % 1280, 100 + i / 1280, 16'h0F0F, 1'b0, 1'b1);
        px(1279, 719, 16'h0000, 1'b0, 1'b1);
        chk("count 500", 32'(collision_count_out), 32'd500);
        chk("frame_done pulse", 32'(frame_done_out), 32'h1);
        idle();
        chk("frame_done one cycle", 32'(frame_done_out), 32'h0);
        chk("count held", 32'(collision_count_out), 32'd500);

        px(5, 200, 16'h5555, 1'b0, 1'b0);
        px(1279, 719, 16'h0000, 1'b0, 1'b0);
        chk("count zero", 32'(collision_count_out), 32'd0);

        cur_gs = 3'd0;
        for (int f = 0; f < 32; f++) begin
            inv = ((f >= 1) && (f <= 15)) || (f == 31);
            px(10, 200, 16'h1234, 1'b0, 1'b0); idle();
            chk($sformatf("flash frame %0d pixel", f), 32'(pixel_out), inv ? 32'hEDCB : 32'h1234);
            chk($sformatf("flash frame %0d active", f), 32'(flash_active_out), 32'(inv));
            px(1279, 719, 16'h0000, 1'b0, 1'b0);
        end

        // Frame 32 is inverted; game resumes mid-frame.
        px(10, 200, 16'h1234, 1'b0, 1'b0);
        cur_gs = 3'd1;
        px(20, 200, 16'h1234, 1'b0, 1'b0); idle();
        chk("resume frame still inverted", 32'(pixel_out), 32'hEDCB);
        px(1279, 719, 16'h0000, 1'b0, 1'b0);
        px(10, 200, 16'h1234, 1'b0, 1'b0); idle();
        chk("resumed pixel", 32'(pixel_out), 32'h1234);
        chk("resumed flash", 32'(flash_active_out), 32'h0);

        // Enter game over, then reset mid-frame.
        cur_gs = 3'd0;
        px(1279, 719, 16'h0000, 1'b0, 1'b0);
        cur_gs = 3'd1;
        for (int i = 0; i < 200; i++) px(i % 1280, 300 + i / 1280, 16'h0F0F, 1'b0, 1'b1);
        rst_in = 1'b0;
        idle();
        rst_in = 1'b1;
        for (int i = 0; i < 7; i++) px(i, 500, 16'h0F0F, 1'b0, 1'b1);
        px(10, 200, 16'h1234, 1'b0, 1'b0); idle();
        chk("post-reset not inverted", 32'(pixel_out), 32'h1234);
        chk("post-reset flash", 32'(flash_active_out), 32'h0);
        px(1279, 719, 16'h0000, 1'b0, 1'b0);
        chk("post-reset count 7", 32'(collision_count_out), 32'd7);
        chk("post-reset frame_done", 32'(frame_done_out), 32'h1);

        repeat (3) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
